// File: rtl/opendap_cdc_bus_pkg.sv
// rtl/opendap_cdc_bus_pkg.sv - shared encodings for the opendap req/ack bus crossing
// Used by the launch end (opendap_cdc_bus_tx) and the future capture end (opendap_cdc_bus_rx).
package opendap_cdc_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RTZ  = 2'd2;

  // Four-phase protocol phases as seen on the (req, ack) wire pair
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_REQ_UP = 2'd1,
    PH_ACK_UP = 2'd2,
    PH_REQ_DN = 2'd3
  } cdc_phase_e;

  function automatic cdc_phase_e cdc_phase(input logic req, input logic ack);
    case ({req, ack})
      2'b10:   return PH_REQ_UP;
      2'b11:   return PH_ACK_UP;
      2'b01:   return PH_REQ_DN;
      default: return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/opendap_sync_1bit.sv
// rtl/opendap_sync_1bit.sv - N-stage flip-flop synchroniser for a single level signal
// Output follows the input after N_STAGES clk edges; reset clears every stage.
module opendap_sync_1bit #(
  parameter int N_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[N_STAGES-1];

endmodule

// File: rtl/opendap_cdc_bus_tx.sv
// rtl/opendap_cdc_bus_tx.sv - launch end of a 4-phase req/ack word crossing
// Holds an accepted word on data_out while req_out is up, then completes return-to-zero.
module opendap_cdc_bus_tx
  import opendap_cdc_bus_pkg::*;
#(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         req_out,
  output logic [W-1:0] data_out,
  input  logic         ack_in,
  output logic         done,
  output logic         busy,
  output logic         timeout,
  input  logic         timeout_clr
);

  logic [1:0]   r_state;
  logic         r_req;
  logic [W-1:0] r_data;
  logic         r_done;
  logic         w_ack_s;
  logic         w_accept;
  logic         w_timeout;

  opendap_sync_1bit #(
    .N_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ack_in),
    .o_q   (w_ack_s)
  );

  // A still-high ack in IDLE (late destination reset) blocks new words until it drops
  assign in_ready = (r_state == ST_IDLE) && !w_ack_s;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data  <= in_data;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= ST_RTZ;
          end
        end
        ST_RTZ: begin
          if (!w_ack_s) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] r_cnt;
      logic          r_timeout;

      // Flag sets on the edge the count reaches TIMEOUT; the handshake keeps waiting
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end else begin
          if (r_state != ST_REQ) begin
            r_cnt <= '0;
          end else if (r_cnt != TW'(TIMEOUT)) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if ((r_state == ST_REQ) && (r_cnt == TW'(TIMEOUT - 1))) begin
            r_timeout <= 1'b1;
          end else if (timeout_clr) begin
            r_timeout <= 1'b0;
          end
        end
      end

      assign w_timeout = r_timeout;
    end else begin : g_no_timeout
      logic w_unused_clr;
      assign w_unused_clr = timeout_clr;
      assign w_timeout    = 1'b0;
    end
  endgenerate

  assign req_out  = r_req;
  assign data_out = r_data;
  assign done     = r_done;
  assign busy     = (r_state != ST_IDLE);
  assign timeout  = w_timeout;

endmodule

// File: tb/tb_opendap_cdc_bus_tx.sv
// tb/tb_opendap_cdc_bus_tx.sv - scoreboard bench for opendap_cdc_bus_tx
// Directed handshake checks plus a randomised destination model in its own clock domain.
module tb_opendap_cdc_bus_tx;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         dclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         req_out;
  logic [W-1:0] data_out;
  logic         ack_in;
  logic         done;
  logic         busy;
  logic         timeout;
  logic         timeout_clr = 1'b0;

  logic ack_man = 1'b0;
  logic ack_model = 1'b0;
  logic dest_auto = 1'b0;
  assign ack_in = dest_auto ? ack_model : ack_man;

  always #5 clk = ~clk;
  always #4 dclk = ~dclk;

  opendap_cdc_bus_tx #(.W(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_in      (ack_in),
    .done        (done),
    .busy        (busy),
    .timeout     (timeout),
    .timeout_clr (timeout_clr)
  );

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int stab_viol = 0;
  int done_dbl = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Destination end: own 2FF synchroniser on req, captures the word, acks after a random delay
  logic d_s1 = 1'b0;
  logic d_s2 = 1'b0;
  always @(posedge dclk) begin
    d_s1 <= req_out;
    d_s2 <= d_s1;
  end

  initial begin : dest_model
    logic [W-1:0] w;
    forever begin
      @(posedge dclk);
      #1;
      if (dest_auto) begin
        if (d_s2 && !ack_model) begin
          rx_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got word %0h expected none", data_out);
          end else begin
            w = exp_q.pop_front();
            chk("rx_data", data_out, w);
          end
          repeat ($urandom_range(0, 20)) @(posedge dclk);
          ack_model = 1'b1;
        end else if (!d_s2 && ack_model) begin
          repeat ($urandom_range(0, 20)) @(posedge dclk);
          ack_model = 1'b0;
        end
      end
    end
  end

  logic         p_busy = 1'b0;
  logic         p_done = 1'b0;
  logic [W-1:0] p_data = '0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && p_done) done_dbl++;
    if (rst_n && p_busy && busy && (data_out != p_data)) stab_viol++;
    p_busy = busy;
    p_done = done;
    p_data = data_out;
  end

  task automatic send(input logic [W-1:0] word);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_wait: in_ready still 0 after %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    if (dest_auto) exp_q.push_back(word);
    acc_cnt++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic xfer_manual(input logic [W-1:0] word, input string tag);
    int n;
    int d0;
    send(word);
    chk({tag, "_data"}, data_out, word);
    chk({tag, "_req"}, req_out, 1);
    ack_man = 1'b1;
    n = 0;
    while (req_out && n < 50) begin tick(); n++; end
    chk({tag, "_req_fall"}, req_out, 0);
    d0 = done_cnt;
    ack_man = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    @(negedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    tick();
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [W-1:0] last_word;
    int n;
    int d0;
    int a0;

    // 1: reset values and a single handshake with exact latencies
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    acc_cnt++;
    chk("t1_req", req_out, 1);
    chk("t1_data", data_out, 32'hDEADBEEF);
    chk("t1_busy", busy, 1);
    chk("t1_ready_busy", in_ready, 0);
    ack_man = 1'b1;
    repeat (SS) tick();
    chk("t1_req_held", req_out, 1);
    tick();
    chk("t1_req_fall", req_out, 0);
    chk("t1_data_rtz", data_out, 32'hDEADBEEF);
    chk("t1_ready_rtz", in_ready, 0);
    ack_man = 1'b0;
    repeat (SS) tick();
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_ready_after", in_ready, 1);
    chk("t1_busy_after", busy, 0);
    tick();
    chk("t1_done_single", done, 0);
    chk("t1_no_timeout", timeout, 0);

    // 3: timeout sets TO cycles after REQ entry, handshake not aborted
    last_word = $urandom;
    send(last_word);
    repeat (TO - 1) tick();
    chk("t3_timeout_early", timeout, 0);
    tick();
    chk("t3_timeout_set", timeout, 1);
    chk("t3_req_kept", req_out, 1);
    repeat (3) tick();
    chk("t3_timeout_sticky", timeout, 1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("t3_timeout_clr", timeout, 0);
    repeat (3) tick();
    chk("t3_timeout_stays_clr", timeout, 0);
    chk("t3_req_still", req_out, 1);
    ack_man = 1'b1;
    n = 0;
    while (req_out && n < 50) begin tick(); n++; end
    chk("t3_req_fall", req_out, 0);
    ack_man = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("t3_complete", busy, 0);
    tick();
    // set wins over a coincident clear
    last_word = $urandom;
    timeout_clr = 1'b1;
    send(last_word);
    repeat (TO) tick();
    chk("t3_set_wins", timeout, 1);
    tick();
    chk("t3_clr_after_set", timeout, 0);
    timeout_clr = 1'b0;
    ack_man = 1'b1;
    n = 0;
    while (req_out && n < 50) begin tick(); n++; end
    ack_man = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    tick();

    // 4: ack high while idle blocks acceptance
    ack_man = 1'b1;
    repeat (SS) tick();
    chk("t4_ready_blocked", in_ready, 0);
    in_valid = 1'b1;
    in_data = 32'h12345678;
    repeat (4) tick();
    chk("t4_no_accept_busy", busy, 0);
    chk("t4_no_accept_req", req_out, 0);
    chk("t4_data_unchanged", data_out, last_word);
    in_valid = 1'b0;
    ack_man = 1'b0;
    tick();
    chk("t4_ready_still_0", in_ready, 0);
    tick();
    chk("t4_ready_back", in_ready, 1);

    // 5: asynchronous reset in REQ and in RTZ
    send(32'h0BADF00D);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_req_rst_req", req_out, 0);
    chk("t5_req_rst_busy", busy, 0);
    chk("t5_req_rst_done", done, 0);
    chk("t5_req_rst_data", data_out, 0);
    tick();
    rst_n = 1'b1;
    send(32'h13579BDF);
    ack_man = 1'b1;
    n = 0;
    while (req_out && n < 50) begin tick(); n++; end
    chk("t5_in_rtz", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rtz_rst_req", req_out, 0);
    chk("t5_rtz_rst_busy", busy, 0);
    chk("t5_rtz_rst_done", done, 0);
    ack_man = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (SS) tick();
    chk("t5_ready_after_rst", in_ready, 1);
    xfer_manual(32'hA5A5A5A5, "t5_fresh");

    // 2 and 6: randomised destination, back-to-back then 1000 random words
    d0 = done_cnt;
    a0 = acc_cnt;
    dest_auto = 1'b1;
    send(32'h1);
    send(32'h2);
    send(32'h3);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send($urandom);
    end
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin tick(); n++; end
    tick();
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("rnd_rx_count", rx_cnt, 1003);
    chk("rnd_accepted", acc_cnt - a0, 1003);
    chk("rnd_done_count", done_cnt - d0, acc_cnt - a0);
    chk("data_stable_in_handshake", stab_viol, 0);
    chk("done_single_cycle", done_dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
